// File: rtl/masked_affine_pkg.sv
// -----------------------------------------------------------------------------
// masked_affine_pkg
// Shared definitions for the masked nibble affine pipeline:
//   aff_mode_e  - run-time affine map select (identity, two permutations, NOT)
//   TX_COUNT_W  - width of the accepted-transaction counter
//   aff_perm()  - bit permutation of a single nibble for a given mode
//   aff_cpl()   - whether a mode carries the complement constant
// -----------------------------------------------------------------------------
package masked_affine_pkg;

   typedef enum logic [1:0] {
      AFF_ID  = 2'd0,
      AFF_A   = 2'd1,
      AFF_B   = 2'd2,
      AFF_NOT = 2'd3
   } aff_mode_e;

   localparam int TX_COUNT_W = 16;

   // Linear part of the map; AFF_ID and AFF_NOT share the identity wiring.
   function automatic logic [3:0] aff_perm(input aff_mode_e mode, input logic [3:0] n);
      case (mode)
         AFF_A:   aff_perm = {n[2], n[1], n[3], n[0]};
         AFF_B:   aff_perm = {n[3], n[2], n[0], n[1]};
         default: aff_perm = n;
      endcase
   endfunction

   // Every mode except identity adds the all-ones constant.
   function automatic logic aff_cpl(input aff_mode_e mode);
      aff_cpl = (mode != AFF_ID);
   endfunction

endpackage

// File: rtl/masked_affine_nibble.sv
// -----------------------------------------------------------------------------
// masked_affine_nibble
// Combinational affine map of one 4-bit nibble of one share.
//   mode   in  2  affine map select
//   cpl_en in  1  add the complement constant (only ever high for share 0)
//   n      in  4  input nibble
//   y      out 4  mapped nibble
// -----------------------------------------------------------------------------
module masked_affine_nibble
   import masked_affine_pkg::*;
(
   input  aff_mode_e  mode,
   input  logic       cpl_en,
   input  logic [3:0] n,
   output logic [3:0] y
);

   assign y = aff_perm(mode, n) ^ {4{cpl_en}};

endmodule

// File: rtl/masked_affine_pipe.sv
// -----------------------------------------------------------------------------
// masked_affine_pipe
// Applies a run-time-selected nibble affine map to every lane of every Boolean
// share, then passes the result through DEPTH valid/ready register stages so
// the following quadratic layer sees only registered (glitch-free) shares.
// The complement constant is added to share 0 only, so the unshared value is
// the unmasked affine map and the masking invariant holds.
//
// Optional build macro: MASKED_AFFINE_REFRESH_EN
//   adds in_rnd and XORs it into shares SHARES-2 and SHARES-1 at stage 0
//   (a share refresh that leaves the unshared value unchanged).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake
//   in_mode              affine map select, captured with the data
//   in_x                 shares, share s at [s*4*LANES +: 4*LANES]
//   in_rnd               refresh mask (only with MASKED_AFFINE_REFRESH_EN)
//   out_valid / out_ready output handshake
//   out_y, out_mode      mapped shares (same packing) and their mode
//   tx_count             accepted transactions, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module masked_affine_pipe
   import masked_affine_pkg::*;
#(
   parameter int SHARES = 3,
   parameter int LANES  = 1,
   parameter int DEPTH  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  in_mode,
   input  logic [SHARES*4*LANES-1:0]   in_x,
`ifdef MASKED_AFFINE_REFRESH_EN
   input  logic [4*LANES-1:0]          in_rnd,
`endif
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SHARES*4*LANES-1:0]   out_y,
   output logic [1:0]                  out_mode,
   output logic [TX_COUNT_W-1:0]       tx_count
);

   localparam int WIDTH = 4 * LANES;
   localparam int DW    = SHARES * WIDTH;

   aff_mode_e       in_mode_e;
   logic [DW-1:0]   map_y;
   logic [DW-1:0]   stage0_d;
   logic            adv;

   logic [DW-1:0]   data_q  [DEPTH];
   logic [1:0]      mode_q  [DEPTH];
   logic [DEPTH-1:0] valid_q;

   assign in_mode_e = aff_mode_e'(in_mode);

   // ---------------------------------------------------------------- affine
   for (genvar s = 0; s < SHARES; s++) begin : g_share
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         masked_affine_nibble u_nib (
            .mode   (in_mode_e),
            .cpl_en ((s == 0) && aff_cpl(in_mode_e)),
            .n      (in_x [s*WIDTH + l*4 +: 4]),
            .y      (map_y[s*WIDTH + l*4 +: 4])
         );
      end
   end

`ifdef MASKED_AFFINE_REFRESH_EN
   // The same mask on two shares cancels in the unshared value.
   // NOTE: always_comb assigns a full default first so no path can infer a latch.
   always_comb begin
      stage0_d = map_y;
      stage0_d[(SHARES-2)*WIDTH +: WIDTH] = map_y[(SHARES-2)*WIDTH +: WIDTH] ^ in_rnd;
      stage0_d[(SHARES-1)*WIDTH +: WIDTH] = map_y[(SHARES-1)*WIDTH +: WIDTH] ^ in_rnd;
   end
`else
   assign stage0_d = map_y;
`endif

   // ------------------------------------------------------------- pipeline
   // Whole pipe moves as one; bubbles are not collapsed.
   assign adv      = !valid_q[DEPTH-1] || out_ready;
   assign in_ready = adv;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the pre-edge value of its predecessor.
   // NOTE: data and mode registers are reset too, because out_y/out_mode must
   // read zero after reset and stale share values must not linger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         tx_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            mode_q[i] <= '0;
         end
      end else begin
         if (adv) begin
            data_q[0]  <= stage0_d;
            mode_q[0]  <= in_mode;
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
               data_q[i]  <= data_q[i-1];
               mode_q[i]  <= mode_q[i-1];
               valid_q[i] <= valid_q[i-1];
            end
         end
         if (in_valid && adv) begin
            tx_count <= tx_count + 1'b1;
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_y     = data_q[DEPTH-1];
   assign out_mode  = mode_q[DEPTH-1];

endmodule
